// File: rtl/dmac_fifo_pkg.sv
// Shared definitions for the DMAC 8-entry FIFO control path: sizes and the
// 3-bit operation state encoding used by the control stage and the calculator.
package dmac_fifo_pkg;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int CW    = 4;

   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'b000,
      WRITE    = 3'b001,
      READ     = 3'b010,
      WR_ERROR = 3'b011,
      RD_ERROR = 3'b100
   } state_e;

endpackage

// File: rtl/dmac_fifo_ns.sv
// Combinational next-state decoder: picks the operation for the coming edge
// from the requests and the projected occupancy of the operation in flight.
module dmac_fifo_ns
   import dmac_fifo_pkg::*;
(
   input  logic          wr_en,
   input  logic          rd_en,
   input  state_e        state,
   input  logic [CW-1:0] next_data_count,
   output state_e        ns
);

   always_comb begin
      ns = IDLE;
      case (state)
         IDLE, WRITE, READ, WR_ERROR, RD_ERROR: begin
            // Simultaneous or absent requests fall through to IDLE.
            if (wr_en && !rd_en) begin
               ns = (next_data_count < DEPTH_CNT) ? WRITE : WR_ERROR;
            end else if (rd_en && !wr_en) begin
               ns = (next_data_count != '0) ? READ : RD_ERROR;
            end
         end
         default: ns = IDLE;
      endcase
   end

endmodule

// File: rtl/dmac_fifo_fsm.sv
// DMAC FIFO control stage: registers state, pointers and count, decodes status
// flags. Define DMAC_FIFO_ERR_CNT_EN to add a saturating error counter output.
module dmac_fifo_fsm
   import dmac_fifo_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic          rd_en,
   input  logic [AW-1:0] next_head,
   input  logic [AW-1:0] next_tail,
   input  logic [CW-1:0] next_data_count,
   output logic [2:0]    state,
   output logic [AW-1:0] head,
   output logic [AW-1:0] tail,
   output logic [CW-1:0] data_count,
   output logic          full,
   output logic          empty,
   output logic          wr_ack,
   output logic          wr_err,
   output logic          rd_ack,
   output logic          rd_err
`ifdef DMAC_FIFO_ERR_CNT_EN
   ,
   output logic [7:0]    err_count
`endif
);

   state_e        state_q, state_d, ns;
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] data_count_q, data_count_d;

   dmac_fifo_ns u_ns (
      .wr_en           (wr_en),
      .rd_en           (rd_en),
      .state           (state_q),
      .next_data_count (next_data_count),
      .ns              (ns)
   );

   // The calculator already holds values in non-moving states, so the
   // register update needs no enable.
   always_comb begin
      state_d      = ns;
      head_d       = next_head;
      tail_d       = next_tail;
      data_count_d = next_data_count;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         head_q       <= '0;
         tail_q       <= '0;
         data_count_q <= '0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         data_count_q <= data_count_d;
      end
   end

`ifdef DMAC_FIFO_ERR_CNT_EN
   logic [7:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (((ns == WR_ERROR) || (ns == RD_ERROR)) && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count_q <= '0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign err_count = err_count_q;
`endif

   assign state      = state_q;
   assign head       = head_q;
   assign tail       = tail_q;
   assign data_count = data_count_q;
   assign full       = (data_count_q == DEPTH_CNT);
   assign empty      = (data_count_q == '0);
   assign wr_ack     = (state_q == WRITE);
   assign wr_err     = (state_q == WR_ERROR);
   assign rd_ack     = (state_q == READ);
   assign rd_err     = (state_q == RD_ERROR);

endmodule

// File: tb/tb_dmac_fifo_fsm.sv
// Bench for dmac_fifo_fsm: a calculator model closes the loop, a vector table
// drives fill/drain/simultaneous traffic, hand sequences cover reset and errors.
module tb_dmac_fifo_fsm;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr_en, rd_en;
   logic [2:0] next_head, next_tail;
   logic [3:0] next_data_count;
   logic [2:0] state, head, tail;
   logic [3:0] data_count;
   logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;
`ifdef DMAC_FIFO_ERR_CNT_EN
   logic [7:0] err_count;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmac_fifo_fsm dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .wr_en           (wr_en),
      .rd_en           (rd_en),
      .next_head       (next_head),
      .next_tail       (next_tail),
      .next_data_count (next_data_count),
      .state           (state),
      .head            (head),
      .tail            (tail),
      .data_count      (data_count),
      .full            (full),
      .empty           (empty),
      .wr_ack          (wr_ack),
      .wr_err          (wr_err),
      .rd_ack          (rd_ack),
      .rd_err          (rd_err)
`ifdef DMAC_FIFO_ERR_CNT_EN
      ,
      .err_count       (err_count)
`endif
   );

   // Address/count calculator model: moves pointers only for WRITE and READ.
   always_comb begin
      next_head       = head;
      next_tail       = tail;
      next_data_count = data_count;
      if (state == 3'b001) begin
         next_tail       = tail + 3'd1;
         next_data_count = data_count + 4'd1;
      end else if (state == 3'b010) begin
         next_head       = head + 3'd1;
         next_data_count = data_count - 4'd1;
      end
   end

   typedef struct {
      logic       wr;
      logic       rd;
      logic [2:0] st;
      logic [2:0] hd;
      logic [2:0] tl;
      logic [3:0] dc;
   } vec_t;

   localparam int NVEC = 26;
   vec_t vecs [NVEC];
   vec_t sb_q [$];

   function automatic vec_t mk(logic wr, logic rd, logic [2:0] st,
                               logic [2:0] hd, logic [2:0] tl, logic [3:0] dc);
      vec_t v;
      v.wr = wr; v.rd = rd; v.st = st; v.hd = hd; v.tl = tl; v.dc = dc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Flags bundle {full, empty, wr_ack, wr_err, rd_ack, rd_err} implied by an expected state/count.
   function automatic logic [5:0] exp_flags(logic [2:0] st, logic [3:0] dc);
      return {dc == 4'd8, dc == 4'd0, st == 3'b001, st == 3'b011, st == 3'b010, st == 3'b100};
   endfunction

   initial begin
      // Expected register values after each edge, derived by hand.
      // Fill: 8 writes acknowledged, 9th overflows; tail wraps to 0.
      vecs[0]  = mk(1, 0, 3'b001, 0, 0, 0);
      vecs[1]  = mk(1, 0, 3'b001, 0, 1, 1);
      vecs[2]  = mk(1, 0, 3'b001, 0, 2, 2);
      vecs[3]  = mk(1, 0, 3'b001, 0, 3, 3);
      vecs[4]  = mk(1, 0, 3'b001, 0, 4, 4);
      vecs[5]  = mk(1, 0, 3'b001, 0, 5, 5);
      vecs[6]  = mk(1, 0, 3'b001, 0, 6, 6);
      vecs[7]  = mk(1, 0, 3'b001, 0, 7, 7);
      vecs[8]  = mk(1, 0, 3'b011, 0, 0, 8);
      vecs[9]  = mk(0, 0, 3'b000, 0, 0, 8);
      // Drain: 8 reads acknowledged, 9th underflows; head wraps to 0.
      vecs[10] = mk(0, 1, 3'b010, 0, 0, 8);
      vecs[11] = mk(0, 1, 3'b010, 1, 0, 7);
      vecs[12] = mk(0, 1, 3'b010, 2, 0, 6);
      vecs[13] = mk(0, 1, 3'b010, 3, 0, 5);
      vecs[14] = mk(0, 1, 3'b010, 4, 0, 4);
      vecs[15] = mk(0, 1, 3'b010, 5, 0, 3);
      vecs[16] = mk(0, 1, 3'b010, 6, 0, 2);
      vecs[17] = mk(0, 1, 3'b010, 7, 0, 1);
      vecs[18] = mk(0, 1, 3'b100, 0, 0, 0);
      vecs[19] = mk(0, 0, 3'b000, 0, 0, 0);
      // Three writes, then simultaneous requests are ignored at count 3.
      vecs[20] = mk(1, 0, 3'b001, 0, 0, 0);
      vecs[21] = mk(1, 0, 3'b001, 0, 1, 1);
      vecs[22] = mk(1, 0, 3'b001, 0, 2, 2);
      vecs[23] = mk(1, 1, 3'b000, 0, 3, 3);
      vecs[24] = mk(1, 1, 3'b000, 0, 3, 3);
      vecs[25] = mk(0, 0, 3'b000, 0, 3, 3);

      wr_en   = 1'b0;
      rd_en   = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_ptrs", 32'({head, tail}), 32'd0);
      chk("reset_count", 32'(data_count), 32'd0);
      chk("reset_flags", 32'({full, empty, wr_ack, wr_err, rd_ack, rd_err}), 32'b010000);
`ifdef DMAC_FIFO_ERR_CNT_EN
      chk("reset_err_count", 32'(err_count), 32'd0);
`endif

      for (int i = 0; i < NVEC; i++) begin
         vec_t e;
         wr_en = vecs[i].wr;
         rd_en = vecs[i].rd;
         sb_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = sb_q.pop_front();
            $display("vec %0d wr=%0b rd=%0b state=%0b head=%0d tail=%0d count=%0d",
                     i, e.wr, e.rd, state, head, tail, data_count);
            chk($sformatf("v%0d_state", i), 32'(state), 32'(e.st));
            chk($sformatf("v%0d_head", i), 32'(head), 32'(e.hd));
            chk($sformatf("v%0d_tail", i), 32'(tail), 32'(e.tl));
            chk($sformatf("v%0d_count", i), 32'(data_count), 32'(e.dc));
            chk($sformatf("v%0d_flags", i), 32'({full, empty, wr_ack, wr_err, rd_ack, rd_err}),
                32'(exp_flags(e.st, e.dc)));
         end
      end
`ifdef DMAC_FIFO_ERR_CNT_EN
      chk("table_err_count", 32'(err_count), 32'd2);
`endif

      // Mid-operation reset: write up to count 5, then reset between edges.
      wr_en = 1'b1;
      rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("burst before reset state=%0b count=%0d", state, data_count);
      chk("pre_reset_count", 32'(data_count), 32'd5);
      chk("pre_reset_state", 32'(state), 32'b001);
      #2;
      reset_n = 1'b0;
      #1;
      $display("async reset state=%0b head=%0d tail=%0d count=%0d", state, head, tail, data_count);
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_ptrs", 32'({head, tail}), 32'd0);
      chk("async_rst_count", 32'(data_count), 32'd0);
      chk("async_rst_flags", 32'({full, empty, wr_ack, wr_err, rd_ack, rd_err}), 32'b010000);
      wr_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_state", 32'(state), 32'd0);

      // Reads on an empty FIFO: every cycle is an underflow.
      rd_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      $display("3 empty reads state=%0b rd_err=%0b count=%0d", state, rd_err, data_count);
      chk("empty_rd_state", 32'(state), 32'b100);
      chk("empty_rd_flags", 32'({full, empty, wr_ack, wr_err, rd_ack, rd_err}), 32'b010001);
`ifdef DMAC_FIFO_ERR_CNT_EN
      chk("err_count_3", 32'(err_count), 32'd3);
`endif
      repeat (297) @(posedge clk);
      #1;
      $display("300 empty reads state=%0b count=%0d head=%0d", state, data_count, head);
      chk("long_rd_count", 32'(data_count), 32'd0);
      chk("long_rd_head", 32'(head), 32'd0);
`ifdef DMAC_FIFO_ERR_CNT_EN
      chk("err_count_sat", 32'(err_count), 32'd255);
`endif
      rd_en = 1'b0;
      @(posedge clk);
      #1;
      chk("final_idle", 32'(state), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
